seq_pair_fetch: RTL and testbench
=================================

// Module: seq_pair_fetch
// PURPOSE
// - Upstream feeder of the match/mismatch stage in the Needleman-Wunsch datapath.
// - Walks score-matrix cells (i,j), i,j = 1..LEN, row-major with j innermost.
// - For each cell, reads symbol A[i-1] and symbol B[j-1] from two synchronous sequence RAMs.
// - Presents each pair on a/b with en_read asserted, then holds it until the consumer accepts it.
// PARAMETERS
// - LEN    8  sequence length; both sequences have equal length; LEN >= 1.
// - AW     3  RAM address width; 2**AW >= LEN.
// - IW     4  cell index width; 2**IW > LEN.
// - SYM_W  3  symbol width (nucleotide code).
// PORTS
// - clk         in   1      system clock, rising edge; the only clock.
// - rst         in   1      reset, asynchronous, active-high.
// - start       in   1      begin a traversal; sampled only in IDLE.
// - ready_in    in   1      consumer accepts the presented pair on this edge.
// - a_addr      out  AW     address to sequence-A RAM.
// - b_addr      out  AW     address to sequence-B RAM.
// - a_data      in   SYM_W  sequence-A RAM data; valid 1 cycle after a_addr.
// - b_data      in   SYM_W  sequence-B RAM data; valid 1 cycle after b_addr.
// - a           out  SYM_W  registered symbol A[i-1].
// - b           out  SYM_W  registered symbol B[j-1].
// - en_read     out  1      a/b valid for the current cell.
// - cell_i      out  IW     row index of the presented pair.
// - cell_j      out  IW     column index of the presented pair.
// - busy        out  1      traversal in progress.
// - done        out  1      one-cycle pulse after the last cell is accepted.
// - sym_err     out  1      sticky invalid-symbol flag (see CONFIGURATION).
// BEHAVIOUR
// - Reset (async assert, takes effect immediately):
//   - state=IDLE.
//   - a=b=0, en_read=0, cell_i=cell_j=1.
//   - a_addr=b_addr=0, busy=0, done=0, sym_err=0.
// - FSM states: IDLE, FETCH, PRESENT, DONE.
// - IDLE:
//   - On start=1, go to FETCH and set i=j=1.
// - FETCH (1 cycle):
//   - Drive a_addr=i-1, b_addr=j-1.
//   - At the end-of-cycle edge, go to PRESENT.
// - PRESENT:
//   - On entry edge, capture a<=a_data and b<=b_data; set en_read=1 and cell_i/j=i/j.
//   - While ready_in=0: a, b, en_read and cell_i/j hold stable.
//   - When en_read=1 and ready_in=1: the pair is accepted on that edge.
//     - Clear en_read, then advance the indices:
//       - j<LEN: j++.
//       - j==LEN and i<LEN: j=1, i++.
//       - j==LEN and i==LEN: go to DONE.
//     - On j<LEN or i<LEN, go back to FETCH.
// - DONE: done=1 for exactly 1 cycle, then return to IDLE.
// - busy=1 in FETCH, PRESENT and DONE.
// - Throughput: 2 cycles per cell with ready_in tied high.
// - Traversal latency: start edge to done = 2*LEN*LEN + 1 cycles.
// - Boundary conditions:
//   - start while busy is ignored.
//   - start in the DONE cycle is ignored.
//   - LEN=1 produces exactly one pair, (1,1).
//   - ready_in while en_read=0 has no effect.
//   - Reset mid-traversal aborts: no done pulse; the next start restarts at (1,1).
// - Index arithmetic is unsigned; addresses are i-1 and j-1 truncated to AW bits.
// CONFIGURATION
// - Macro: SYM_CHECK_EN.
// - Defined:
//   - Valid codes are 0..4 (A, C, G, T, gap).
//   - On the PRESENT capture edge, if a_data>4 or b_data>4, sym_err<=1.
//   - sym_err stays set until rst or the next accepted start.
//   - Traversal is not stalled by an invalid symbol.
// - Undefined: sym_err is tied to 0 and no compare logic is built.
// STRUCTURE
// - Shared package nw_pkg:
//   - SYM_W.
//   - Symbol code constants SYM_A=0, SYM_C=1, SYM_G=2, SYM_T=3, SYM_GAP=4, SYM_MAX=4.
//   - FSM state encoding for IDLE/FETCH/PRESENT/DONE.
// - Sub-module nw_ij_counter:
//   - Nested i/j counter with clear, advance and last outputs.
//   - Shared with the traceback address generator.
// TESTING
// - LEN=4, A=ACGT, B=AGGT, ready_in=1, start pulse:
//   - 16 pairs in order (1,1),(1,2)..(4,4).
//   - Pair (2,2) is a=1, b=2.
//   - done arrives exactly 33 cycles after start.
// - Stall: drop ready_in for 5 cycles while presenting pair (2,3):
//   - a, b, cell_i/j and en_read stay constant.
//   - No pair is skipped or duplicated.
// - Reset mid-traversal: assert rst at pair (3,1), then start again:
//   - Outputs clear immediately, with no done pulse.
//   - The new run begins at (1,1) with a_addr=b_addr=0.
// - Ignored start: pulse start during pair (1,2) and in the DONE cycle:
//   - Sequence unaffected.
//   - Exactly one done per accepted start.
// - LEN=1 edge case: a single pair (1,1), then done; busy drops after 3 cycles.
// - SYM_CHECK_EN defined, with A[2]=7:
//   - sym_err rises at the capture of row 3 and stays high.
//   - With the macro undefined, sym_err=0 throughout.

Source files
------------

// File: rtl/nw_pkg.sv
// Shared Needleman-Wunsch definitions: symbol width, nucleotide codes and the
// fetch FSM state encoding.
package nw_pkg;

   localparam int unsigned SYM_W = 3;

   localparam logic [SYM_W-1:0] SYM_A   = SYM_W'(0);
   localparam logic [SYM_W-1:0] SYM_C   = SYM_W'(1);
   localparam logic [SYM_W-1:0] SYM_G   = SYM_W'(2);
   localparam logic [SYM_W-1:0] SYM_T   = SYM_W'(3);
   localparam logic [SYM_W-1:0] SYM_GAP = SYM_W'(4);
   localparam logic [SYM_W-1:0] SYM_MAX = SYM_W'(4);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_PRESENT = 2'd2,
      ST_DONE    = 2'd3
   } nw_state_t;

endpackage

// File: rtl/nw_ij_counter.sv
// Nested 1-based (i,j) cell counter, j innermost; shared by the pair fetcher
// and the traceback address generator.
module nw_ij_counter #(
   parameter int unsigned LEN = 8,
   parameter int unsigned IW  = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          advance,
   output logic [IW-1:0] i,
   output logic [IW-1:0] j,
   output logic          row_end_c,
   output logic          last_c
);

   logic [IW-1:0] i_q, i_d, j_q, j_d;

   assign row_end_c = (j_q == IW'(LEN));
   assign last_c    = row_end_c && (i_q == IW'(LEN));

   always_comb begin
      i_d = i_q;
      j_d = j_q;
      if (clear) begin
         i_d = IW'(1);
         j_d = IW'(1);
      end else if (advance) begin
         if (row_end_c) begin
            j_d = IW'(1);
            i_d = i_q + IW'(1);
         end else begin
            j_d = j_q + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_q <= IW'(1);
         j_q <= IW'(1);
      end else begin
         i_q <= i_d;
         j_q <= j_d;
      end
   end

   assign i = i_q;
   assign j = j_q;

endmodule

// File: rtl/seq_pair_fetch.sv
// Walks the LEN x LEN score matrix and presents (A[i-1], B[j-1]) pairs with a
// ready handshake. Optional invalid-symbol flag built under SYM_CHECK_EN.
module seq_pair_fetch
   import nw_pkg::*;
#(
   parameter int unsigned LEN = 8,
   parameter int unsigned AW  = 3,
   parameter int unsigned IW  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             ready_in,
   output logic [AW-1:0]    a_addr,
   output logic [AW-1:0]    b_addr,
   input  logic [SYM_W-1:0] a_data,
   input  logic [SYM_W-1:0] b_data,
   output logic [SYM_W-1:0] a,
   output logic [SYM_W-1:0] b,
   output logic             en_read,
   output logic [IW-1:0]    cell_i,
   output logic [IW-1:0]    cell_j,
   output logic             busy,
   output logic             done,
   output logic             sym_err
);

   nw_state_t        state_q, state_d;
   logic [AW-1:0]    a_addr_q, a_addr_d, b_addr_q, b_addr_d;
   logic [SYM_W-1:0] a_q, a_d, b_q, b_d;
   logic             en_read_q, en_read_d, busy_q, busy_d, done_q, done_d;
   logic [IW-1:0]    cell_i_q, cell_i_d, cell_j_q, cell_j_d;
   logic             ctr_clear, ctr_adv, ctr_row_end, ctr_last;
   logic [IW-1:0]    ctr_i, ctr_j;
   logic             accept_c;

   nw_ij_counter #(.LEN(LEN), .IW(IW)) u_ctr (
      .clk       (clk),
      .rst       (rst),
      .clear     (ctr_clear),
      .advance   (ctr_adv),
      .i         (ctr_i),
      .j         (ctr_j),
      .row_end_c (ctr_row_end),
      .last_c    (ctr_last)
   );

   assign accept_c = en_read_q && ready_in;

   // Next-state and next-output logic; addresses are loaded on every FETCH entry
   always_comb begin
      state_d   = state_q;
      a_addr_d  = a_addr_q;
      b_addr_d  = b_addr_q;
      a_d       = a_q;
      b_d       = b_q;
      en_read_d = en_read_q;
      cell_i_d  = cell_i_q;
      cell_j_d  = cell_j_q;
      done_d    = 1'b0;
      ctr_clear = 1'b0;
      ctr_adv   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               ctr_clear = 1'b1;
               a_addr_d  = '0;
               b_addr_d  = '0;
               state_d   = ST_FETCH;
            end
         end
         ST_FETCH: begin
            a_d       = a_data;
            b_d       = b_data;
            en_read_d = 1'b1;
            cell_i_d  = ctr_i;
            cell_j_d  = ctr_j;
            state_d   = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (accept_c) begin
               en_read_d = 1'b0;
               if (ctr_last) begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  ctr_adv = 1'b1;
                  state_d = ST_FETCH;
                  // Row wrap: next row index i maps to address i, column restarts at 0
                  if (ctr_row_end) begin
                     a_addr_d = AW'(ctr_i);
                     b_addr_d = '0;
                  end else begin
                     a_addr_d = AW'(ctr_i - IW'(1));
                     b_addr_d = AW'(ctr_j);
                  end
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         a_addr_q  <= '0;
         b_addr_q  <= '0;
         a_q       <= '0;
         b_q       <= '0;
         en_read_q <= 1'b0;
         cell_i_q  <= IW'(1);
         cell_j_q  <= IW'(1);
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_addr_q  <= a_addr_d;
         b_addr_q  <= b_addr_d;
         a_q       <= a_d;
         b_q       <= b_d;
         en_read_q <= en_read_d;
         cell_i_q  <= cell_i_d;
         cell_j_q  <= cell_j_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

`ifdef SYM_CHECK_EN
   logic sym_err_q, sym_err_d;

   // Sticky until the next accepted start; never stalls the walk
   always_comb begin
      sym_err_d = sym_err_q;
      if (state_q == ST_IDLE && start) begin
         sym_err_d = 1'b0;
      end else if (state_q == ST_FETCH && (a_data > SYM_MAX || b_data > SYM_MAX)) begin
         sym_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sym_err_q <= 1'b0;
      else     sym_err_q <= sym_err_d;
   end

   assign sym_err = sym_err_q;
`else
   assign sym_err = 1'b0;
`endif

   assign a_addr  = a_addr_q;
   assign b_addr  = b_addr_q;
   assign a       = a_q;
   assign b       = b_q;
   assign en_read = en_read_q;
   assign cell_i  = cell_i_q;
   assign cell_j  = cell_j_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_seq_pair_fetch.sv
// Bench for seq_pair_fetch: LEN=4 and LEN=1 instances against a queue-based
// expected-pair model; sym_err expectations follow SYM_CHECK_EN.
module tb_seq_pair_fetch;
   import nw_pkg::*;

   localparam int unsigned L4 = 4, AW4 = 2, IW4 = 4;
   localparam int unsigned L1 = 1, AW1 = 1, IW1 = 2;
`ifdef SYM_CHECK_EN
   localparam bit SYM_ON = 1'b1;
`else
   localparam bit SYM_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start4, ready4, start1, ready1;
   logic [AW4-1:0]   a_addr4, b_addr4;
   logic [AW1-1:0]   a_addr1, b_addr1;
   logic [SYM_W-1:0] a_data4, b_data4, a_data1, b_data1, a4, b4, a1, b1;
   logic [IW4-1:0]   ci4, cj4;
   logic [IW1-1:0]   ci1, cj1;
   logic             en4, busy4, done4, serr4, en1, busy1, done1, serr1;
   logic [SYM_W-1:0] mem_a [L4];
   logic [SYM_W-1:0] mem_b [L4];
   logic [SYM_W-1:0] mem_a1 [2];
   logic [SYM_W-1:0] mem_b1 [2];

   int checks = 0;
   int errors = 0;

   // Synchronous RAM models: data for the address driven this cycle is ready by its end
   always @(negedge clk) begin
      a_data4 <= mem_a[a_addr4];
      b_data4 <= mem_b[b_addr4];
      a_data1 <= mem_a1[a_addr1];
      b_data1 <= mem_b1[b_addr1];
   end

   seq_pair_fetch #(.LEN(L4), .AW(AW4), .IW(IW4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .ready_in(ready4),
      .a_addr(a_addr4), .b_addr(b_addr4), .a_data(a_data4), .b_data(b_data4),
      .a(a4), .b(b4), .en_read(en4), .cell_i(ci4), .cell_j(cj4),
      .busy(busy4), .done(done4), .sym_err(serr4)
   );

   seq_pair_fetch #(.LEN(L1), .AW(AW1), .IW(IW1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .ready_in(ready1),
      .a_addr(a_addr1), .b_addr(b_addr1), .a_data(a_data1), .b_data(b_data1),
      .a(a1), .b(b1), .en_read(en1), .cell_i(ci1), .cell_j(cj1),
      .busy(busy1), .done(done1), .sym_err(serr1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One LEN=4 traversal; model = row-major list of (i,j) and A[i-1]/B[j-1] lookups
   task automatic run4(input bit rnd, input bit stall, input bit poke, input bit bad,
                       input bit abort);
      int qi[$];
      int qj[$];
      int cyc = 0;
      int stall_left = 0;
      bit stall_used = 1'b0;
      bit finished = 1'b0;
      bit aborted = 1'b0;
      bit prev_hold = 1'b0;
      logic [31:0] pa = 0, pb = 0, pi = 0, pj = 0;
      for (int i = 1; i <= int'(L4); i++)
         for (int j = 1; j <= int'(L4); j++) begin
            qi.push_back(i);
            qj.push_back(j);
         end
      @(negedge clk);
      start4 = 1'b1;
      ready4 = 1'b1;
      while (!finished && cyc < 400) begin
         @(negedge clk);
         cyc++;
         start4 = 1'b0;
         if (cyc == 1) begin
            chk("fetch_a_addr", 32'(a_addr4), 0);
            chk("fetch_b_addr", 32'(b_addr4), 0);
            chk("fetch_busy", 32'(busy4), 1);
            chk("fetch_no_en", 32'(en4), 0);
         end
         if (prev_hold) begin
            chk("hold_en", 32'(en4), 1);
            chk("hold_a", 32'(a4), pa);
            chk("hold_b", 32'(b4), pb);
            chk("hold_i", 32'(ci4), pi);
            chk("hold_j", 32'(cj4), pj);
         end
         if (done4) begin
            finished = 1'b1;
            chk("pairs_left", 32'(qi.size()), 0);
            chk("done_sym_err", 32'(serr4), 32'(bad && SYM_ON));
            if (!rnd && !stall) chk("done_latency", 32'(cyc), 2 * L4 * L4 + 1);
            if (poke) start4 = 1'b1;
            prev_hold = 1'b0;
         end else begin
            ready4 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            prev_hold = 1'b0;
            if (en4) begin
               if (qi.size() == 0) begin
                  chk("extra_pair", 1, 0);
                  finished = 1'b1;
               end else if (abort && qi[0] == 3 && qj[0] == 1) begin
                  rst = 1'b1;
                  #1;
                  chk("abort_en", 32'(en4), 0);
                  chk("abort_busy", 32'(busy4), 0);
                  chk("abort_a", 32'(a4), 0);
                  chk("abort_b", 32'(b4), 0);
                  chk("abort_i", 32'(ci4), 1);
                  chk("abort_j", 32'(cj4), 1);
                  chk("abort_a_addr", 32'(a_addr4), 0);
                  chk("abort_done", 32'(done4), 0);
                  chk("abort_sym_err", 32'(serr4), 0);
                  @(negedge clk);
                  rst = 1'b0;
                  repeat (4) begin
                     @(negedge clk);
                     chk("abort_no_done", 32'(done4), 0);
                     chk("abort_idle", 32'(busy4), 0);
                  end
                  aborted = 1'b1;
                  finished = 1'b1;
               end else begin
                  if (stall && !stall_used && qi[0] == 2 && qj[0] == 3) begin
                     stall_used = 1'b1;
                     stall_left = 5;
                  end
                  if (stall_left > 0) begin
                     ready4 = 1'b0;
                     stall_left--;
                  end
                  if (poke && qi[0] == 1 && qj[0] == 2) start4 = 1'b1;
                  if (ready4) begin
                     chk("pair_i", 32'(ci4), 32'(qi[0]));
                     chk("pair_j", 32'(cj4), 32'(qj[0]));
                     chk("pair_a", 32'(a4), 32'(mem_a[qi[0]-1]));
                     chk("pair_b", 32'(b4), 32'(mem_b[qj[0]-1]));
                     chk("pair_sym_err", 32'(serr4), 32'(bad && SYM_ON && qi[0] >= 3));
                     void'(qi.pop_front());
                     void'(qj.pop_front());
                  end else begin
                     prev_hold = 1'b1;
                     pa = 32'(a4);
                     pb = 32'(b4);
                     pi = 32'(ci4);
                     pj = 32'(cj4);
                  end
               end
            end
         end
      end
      if (!finished) chk("done_timeout", 0, 1);
      if (finished && !aborted) begin
         @(negedge clk);
         start4 = 1'b0;
         ready4 = 1'b1;
         repeat (3) begin
            chk("after_done_idle", 32'(busy4), 0);
            chk("after_done_single", 32'(done4), 0);
            chk("after_done_sym_err", 32'(serr4), 32'(bad && SYM_ON));
            @(negedge clk);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      start4 = 1'b0;
      ready4 = 1'b0;
      start1 = 1'b0;
      ready1 = 1'b1;
      mem_a[0] = SYM_A; mem_a[1] = SYM_C; mem_a[2] = SYM_G; mem_a[3] = SYM_T;
      mem_b[0] = SYM_A; mem_b[1] = SYM_G; mem_b[2] = SYM_G; mem_b[3] = SYM_T;
      mem_a1[0] = SYM_T; mem_a1[1] = SYM_A;
      mem_b1[0] = SYM_GAP; mem_b1[1] = SYM_A;
      repeat (2) @(negedge clk);
      chk("rst_en", 32'(en4), 0);
      chk("rst_busy", 32'(busy4), 0);
      chk("rst_done", 32'(done4), 0);
      chk("rst_i", 32'(ci4), 1);
      chk("rst_j", 32'(cj4), 1);
      chk("rst_a", 32'(a4), 0);
      chk("rst_b_addr", 32'(b_addr4), 0);
      chk("rst_sym_err", 32'(serr4), 0);
      rst = 1'b0;
      ready4 = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_ready_no_effect", 32'(en4), 0);
      chk("idle_not_busy", 32'(busy4), 0);

      run4(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // ACGT vs AGGT, ready high
      run4(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  // stall at (2,3), ignored starts
      run4(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  // reset at (3,1)
      run4(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // restart from (1,1)
      mem_a[2] = SYM_W'(7);
      run4(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);  // invalid symbol in row 3
      mem_a[2] = SYM_G;
      run4(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // flag cleared by new start
      repeat (3) begin
         for (int k = 0; k < int'(L4); k++) begin
            mem_a[k] = SYM_W'($urandom_range(0, 4));
            mem_b[k] = SYM_W'($urandom_range(0, 4));
         end
         run4(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // LEN=1: one pair, done, busy low after three cycles
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("len1_fetch_busy", 32'(busy1), 1);
      chk("len1_fetch_en", 32'(en1), 0);
      chk("len1_fetch_addr", 32'(a_addr1), 0);
      @(negedge clk);
      chk("len1_en", 32'(en1), 1);
      chk("len1_i", 32'(ci1), 1);
      chk("len1_j", 32'(cj1), 1);
      chk("len1_a", 32'(a1), 32'(mem_a1[0]));
      chk("len1_b", 32'(b1), 32'(mem_b1[0]));
      @(negedge clk);
      chk("len1_done", 32'(done1), 1);
      chk("len1_done_busy", 32'(busy1), 1);
      chk("len1_done_en", 32'(en1), 0);
      @(negedge clk);
      chk("len1_idle_busy", 32'(busy1), 0);
      chk("len1_idle_done", 32'(done1), 0);
      chk("len1_sym_err", 32'(serr1), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
